// File: rtl/adc_frame_sched.sv
// adc_frame_sched: frame scheduler for the three-lane ADC serial shifter.
// Buffers 8-bit sample triples in a 4-entry FIFO, divides clk down to a frame
// tick, loads the shifter's parallel inputs, pulses sample_clk for two cycles
// and waits for adc_strobe to close the frame. Sticky underrun/overrun/timeout.
// Optional strobe watchdog: define ADC_SCHED_TIMEOUT_EN.
module adc_frame_sched #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned TO_CYCLES = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [7:0]       wr_data0_i,
    input  logic [7:0]       wr_data1_i,
    input  logic [7:0]       wr_data2_i,
    input  logic             adc_strobe_i,
    output logic             sample_clk_o,
    output logic [7:0]       reg_0_in_o,
    output logic [7:0]       reg_1_in_o,
    output logic [7:0]       reg_2_in_o,
    output logic [2:0]       level_o,
    output logic             busy_o,
    input  logic             clr_flags_i,
    output logic             underrun_o,
    output logic             overrun_o,
    output logic             timeout_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int unsigned Depth = 4;
    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StArm, StWait} state_e;

    // FIFO
    logic [23:0] mem_q [Depth];
    logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]  count_q, count_d;
    logic        full, empty, push, pop;

    // Divider
    logic [DIV_W-1:0] cnt_q, cnt_d, div_eff;
    logic             tick;

    // Frame control
    state_e      state_q, state_d;
    logic        arm_cnt_q, arm_cnt_d;
    logic        sample_clk_q, sample_clk_d;
    logic [23:0] load_q, load_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_done;
    logic        underrun_q, underrun_d, underrun_set;
    logic        overrun_q, overrun_d, overrun_set;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TO_CYCLES + 1);
    localparam logic [WdW-1:0] WdLoad = WdW'(TO_CYCLES);
    localparam logic [WdW-1:0] WdOne  = WdW'(1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d, timeout_set;
`endif

    assign full       = (count_q == 3'd4);
    assign empty      = (count_q == 3'd0);
    assign wr_ready_o = !full;
    assign push       = wr_valid_i && !full;

    // div of 0 behaves as 1; >= keeps the counter bounded if div shrinks mid-count
    assign div_eff = (div_i == '0) ? DivOne : div_i;
    assign tick    = enable_i && (cnt_q >= (div_eff - DivOne));

    // Divider, FIFO pointer and occupancy next-state
    always_comb begin
        cnt_d = '0;
        if (enable_i && !tick) begin
            cnt_d = cnt_q + DivOne;
        end
        wptr_d = push ? wptr_q + 2'd1 : wptr_q;
        rptr_d = pop  ? rptr_q + 2'd1 : rptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Frame FSM next-state and status-set events
    always_comb begin
        state_d      = state_q;
        arm_cnt_d    = arm_cnt_q;
        pop          = 1'b0;
        underrun_set = 1'b0;
        frame_done   = 1'b0;
        load_d       = load_q;
`ifdef ADC_SCHED_TIMEOUT_EN
        wd_d         = wd_q;
        timeout_set  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StLoad;
                    if (empty) begin
                        underrun_set = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        load_d = mem_q[rptr_q];
                    end
                end
            end
            StLoad: begin
                state_d   = StArm;
                arm_cnt_d = 1'b0;
            end
            StArm: begin
                arm_cnt_d = 1'b1;
                if (arm_cnt_q) begin
                    state_d = StWait;
`ifdef ADC_SCHED_TIMEOUT_EN
                    wd_d    = WdLoad;
`endif
                end
            end
            StWait: begin
                if (adc_strobe_i) begin
                    state_d    = StIdle;
                    frame_done = 1'b1;
`ifdef ADC_SCHED_TIMEOUT_EN
                end else if (wd_q == WdOne) begin
                    state_d     = StIdle;
                    timeout_set = 1'b1;
                end else begin
                    wd_d = wd_q - WdOne;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        overrun_set  = tick && (state_q != StIdle);
        sample_clk_d = (state_d == StArm);
        frame_cnt_d  = frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;
        // A set event in the same cycle as clr_flags wins
        underrun_d   = underrun_set | (underrun_q & !clr_flags_i);
        overrun_d    = overrun_set  | (overrun_q  & !clr_flags_i);
`ifdef ADC_SCHED_TIMEOUT_EN
        timeout_d    = timeout_set  | (timeout_q  & !clr_flags_i);
`endif
    end

    // FIFO storage; occupancy gates every read so the array needs no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= {wr_data2_i, wr_data1_i, wr_data0_i};
        end
    end

    // Control and status state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q        <= '0;
            wptr_q       <= 2'd0;
            rptr_q       <= 2'd0;
            count_q      <= 3'd0;
            state_q      <= StIdle;
            arm_cnt_q    <= 1'b0;
            sample_clk_q <= 1'b0;
            load_q       <= 24'd0;
            frame_cnt_q  <= 16'd0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            sample_clk_q <= sample_clk_d;
            load_q       <= load_d;
            frame_cnt_q  <= frame_cnt_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    // Strobe watchdog and sticky timeout flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Watchdog compiled out; the parameter is still accepted for compatibility
    localparam bit ToParamSeen = (TO_CYCLES != 0);
    assign timeout_o = ToParamSeen & 1'b0;
`endif

    assign sample_clk_o = sample_clk_q;
    assign reg_0_in_o   = load_q[7:0];
    assign reg_1_in_o   = load_q[15:8];
    assign reg_2_in_o   = load_q[23:16];
    assign level_o      = count_q;
    assign busy_o       = (state_q != StIdle);
    assign underrun_o   = underrun_q;
    assign overrun_o    = overrun_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: doc/adc_frame_sched.md
# adc_frame_sched

Frame scheduler for the three-lane ADC serial shifter. Buffers 8-bit sample triples in a 4-entry FIFO and divides the shift clock down to a programmable frame rate. On each frame tick it presents the next triple on the shifter's parallel load inputs, then pulses the shifter's sample-clock input. It waits for the shifter's `adc_strobe` to close the frame and keeps sticky underrun, overrun and timeout status for the host.

## Interface
- `DIV_W`, 16, width of frame-period divisor
- `TO_CYCLES`, 32, strobe watchdog length in clk cycles (used only with `ADC_SCHED_TIMEOUT_EN`)
- `clk` in 1: shift clock, same clock as the shifter; all logic on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `enable` in 1: runs the frame divider
- `div` in DIV_W: frame period in clk cycles; 0 is treated as 1
- `wr_valid` in 1: host sample triple valid
- `wr_ready` out 1: FIFO not full
- `wr_data0` / `wr_data1` / `wr_data2` in 8 each: triple for lanes 0/1/2
- `adc_strobe` in 1: end-of-conversion strobe from the shifter
- `sample_clk` out 1: registered; drives the shifter's slow sample-clock input
- `reg_0_in` / `reg_1_in` / `reg_2_in` out 8 each: registered parallel load values to the shifter
- `level` out 3: FIFO occupancy, 0..4
- `busy` out 1: state != IDLE
- `clr_flags` in 1: clears the sticky flags
- `underrun` / `overrun` / `timeout` out 1 each: sticky status flags
- `frame_cnt` out 16: count of completed frames, wraps

## Operation
- Reset values: all outputs 0, `wr_ready`=1, FIFO empty, divider 0, state IDLE.
- FIFO: depth 4.
  - Write occurs when `wr_valid && wr_ready`; `wr_ready` = !full.
  - Write and pop in the same cycle are both legal; `level` is unchanged.
- Divider:
  - While `enable`=1, `cnt` increments. When `cnt` == max(`div`,1)-1, it asserts one-cycle `tick` and wraps to 0.
  - While `enable`=0, `cnt` is held at 0 and no ticks occur.
- State machine, 2-bit:
  - IDLE: on `tick`, go to LOAD.
    - FIFO non-empty: pop the head into `reg_*_in`.
    - FIFO empty: keep the previous `reg_*_in` (repeat the last sample) and set `underrun`.
  - LOAD: one settle cycle, `sample_clk`=0. Go to ARM.
  - ARM: `sample_clk`=1 for exactly 2 cycles. Go to WAIT.
  - WAIT: `sample_clk`=0. On `adc_strobe`=1, go to IDLE and increment `frame_cnt`.
- `tick` in any state other than IDLE: the tick is dropped and `overrun` is set.
- `enable` deasserted mid-frame: the current frame runs to completion; no new ticks follow.
- Simultaneous write to an empty FIFO and pop attempt: the pop sees empty, so `underrun` is set. The written triple enters the FIFO and is used on the next tick.
- `clr_flags` in the same cycle as a set event: set wins.
- `reg_*_in` change only on the IDLE→LOAD edge. They are stable for at least 1 cycle before `sample_clk` rises and until the next frame.

## Timing
- Tick at cycle T:
  - `reg_*_in` update at T+1.
  - `sample_clk` high during T+2 and T+3, low from T+4.
- Minimum frame, strobe seen in the first WAIT cycle: 5 cycles, from tick to IDLE.
  - `div` below 5 guarantees overrun.
  - The shifter's own frame (8 shifts plus 2 strobe states plus wait) requires `div` ≥ 16 for overrun-free operation.
- `adc_strobe` is sampled synchronously. A strobe outside WAIT is ignored.
- `frame_cnt` updates in the cycle after the accepted strobe. It wraps from 0xFFFF to 0.
- Asynchronous reset mid-frame:
  - `sample_clk` and `reg_*_in` go to 0 immediately.
  - The FIFO is emptied.

## Configuration
- `ADC_SCHED_TIMEOUT_EN` defined: strobe watchdog compiled in.
  - The watchdog counter loads `TO_CYCLES` on entry to WAIT.
  - On expiry without a strobe: go to IDLE, set `timeout`, do not increment `frame_cnt`.
- `ADC_SCHED_TIMEOUT_EN` undefined: WAIT holds indefinitely for the strobe.
  - `timeout` is tied to 0.
  - No watchdog logic is present.

## Test plan
- Reset, write triples (0x11,0x22,0x33) and (0x44,0x55,0x66), `div`=20, `enable`=1.
  - First tick: `reg_*_in`=11/22/33 one cycle after the tick; `sample_clk` high 2 cycles.
  - After strobe: `frame_cnt`=1.
  - Next frame: 44/55/66.
- Empty FIFO at tick → `underrun`=1, `reg_*_in` repeat the last triple, frame still runs. `clr_flags` → `underrun`=0.
- `div`=3 with strobe 1 cycle after WAIT entry → `overrun`=1; `frame_cnt` increments once per completed frame only.
- Write 5 triples back-to-back with `enable`=0 → `level`=4, `wr_ready`=0, fifth write rejected, FIFO contents intact.
- With `ADC_SCHED_TIMEOUT_EN`, no strobe → IDLE after 32 WAIT cycles, `timeout`=1, `frame_cnt` unchanged. Without the macro → `busy` stays 1.
- Assert `reset` during ARM → `sample_clk`=0, `level`=0, `busy`=0 immediately; normal operation after release.
